// File: rtl/jala_pkg.sv
// Shared JALA CPU constants: address width, stack base/limit positions and
// the memory address mux select encodings.
package jala_pkg;

  localparam int ADDR_W = 16;

  // Both stacks grow downward from BASE; LIMIT is the lowest legal slot.
  localparam logic [ADDR_W-1:0] MS_BASE  = 16'hFFFE;
  localparam logic [ADDR_W-1:0] MS_LIMIT = 16'hF000;
  localparam logic [ADDR_W-1:0] RS_BASE  = 16'hEFFE;
  localparam logic [ADDR_W-1:0] RS_LIMIT = 16'hE000;

  // Select encodings for the memory address mux (MemDst1/MemDst2).
  typedef enum logic [1:0] {
    MEM_DST_TOP    = 2'b00,
    MEM_DST_SECOND = 2'b01,
    MEM_DST_RS_TOP = 2'b10
  } mem_dst_e;

  // Pointer one slot above sp (toward BASE), modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] slot_above(input logic [ADDR_W-1:0] sp);
    return sp + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/stack_pointer_unit_if.sv
// Control/status bundle between the control FSM and the stack pointer unit.
interface stack_pointer_unit_if;
  import jala_pkg::*;

  // Controls from the FSM
  logic              MSPop;
  logic              MSPWrite;
  logic              MSPRegReset;
  logic              RSPop;
  logic              RSPWrite;
  logic              RSPRegReset;

  // Pointer and status outputs
  logic [ADDR_W-1:0] msp;
  logic [ADDR_W-1:0] msp_next;
  logic [ADDR_W-1:0] rsp;
  logic [ADDR_W-1:0] ms_depth;
  logic [ADDR_W-1:0] rs_depth;
  logic              ms_empty;
  logic              ms_full;
  logic              rs_empty;
  logic              rs_full;
  logic              ms_ovf;
  logic              ms_unf;
  logic              rs_ovf;
  logic              rs_unf;

  // Control FSM side
  modport master (
    output MSPop, MSPWrite, MSPRegReset, RSPop, RSPWrite, RSPRegReset,
    input  msp, msp_next, rsp, ms_depth, rs_depth,
    input  ms_empty, ms_full, rs_empty, rs_full,
    input  ms_ovf, ms_unf, rs_ovf, rs_unf
  );

  // Stack pointer unit side
  modport slave (
    input  MSPop, MSPWrite, MSPRegReset, RSPop, RSPWrite, RSPRegReset,
    output msp, msp_next, rsp, ms_depth, rs_depth,
    output ms_empty, ms_full, rs_empty, rs_full,
    output ms_ovf, ms_unf, rs_ovf, rs_unf
  );

endinterface

// File: rtl/stack_pointer_unit_stack_ptr.sv
// One downward-growing stack pointer with bounds checking and sticky
// overflow/underflow flags. A blocked push/pop holds the pointer.
module stack_ptr #(
  parameter int                ADDR_W = 16,
  parameter logic [ADDR_W-1:0] BASE   = 16'hFFFE,
  parameter logic [ADDR_W-1:0] LIMIT  = 16'hF000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pop,
  input  logic              we,
  input  logic              sreset,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] depth,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] sp_nxt;
  logic              ovf_nxt;
  logic              unf_nxt;

  // Status is decoded straight from the pointer register.
  assign empty = (sp == BASE);
  assign full  = (sp == LIMIT);
  assign depth = BASE - sp;

  // Next pointer/flags: soft re-init wins over an update; blocked moves only flag.
  always_comb begin
    sp_nxt  = sp;
    ovf_nxt = ovf;
    unf_nxt = unf;
    if (sreset) begin
      sp_nxt  = BASE;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
    end else if (we) begin
      if (pop) begin
        if (empty) begin
          unf_nxt = 1'b1;
        end else begin
          sp_nxt = sp + ONE;
        end
      end else begin
        if (full) begin
          ovf_nxt = 1'b1;
        end else begin
          sp_nxt = sp - ONE;
        end
      end
    end else begin
      sp_nxt = sp;
    end
  end

  // Pointer and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp  <= BASE;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      sp  <= sp_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end

endmodule

// File: rtl/stack_pointer_unit.sv
// JALA main/return stack pointer unit: two independent stack_ptr instances
// plus the second-of-stack address for the main stack.
module stack_pointer_unit
  import jala_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MAIN_BASE  = MS_BASE,
  parameter logic [ADDR_W-1:0] MAIN_LIMIT = MS_LIMIT,
  parameter logic [ADDR_W-1:0] RET_BASE   = RS_BASE,
  parameter logic [ADDR_W-1:0] RET_LIMIT  = RS_LIMIT
) (
  input logic                 clk,
  input logic                 rst,
  stack_pointer_unit_if.slave bus
);

  logic [ADDR_W-1:0] ms_sp;
  logic [ADDR_W-1:0] ms_dep;
  logic [ADDR_W-1:0] rs_sp;
  logic [ADDR_W-1:0] rs_dep;
  logic              ms_e, ms_f, ms_o, ms_u;
  logic              rs_e, rs_f, rs_o, rs_u;

  stack_ptr #(
    .ADDR_W (ADDR_W),
    .BASE   (MAIN_BASE),
    .LIMIT  (MAIN_LIMIT)
  ) u_ms (
    .clk    (clk),
    .rst    (rst),
    .pop    (bus.MSPop),
    .we     (bus.MSPWrite),
    .sreset (bus.MSPRegReset),
    .sp     (ms_sp),
    .depth  (ms_dep),
    .empty  (ms_e),
    .full   (ms_f),
    .ovf    (ms_o),
    .unf    (ms_u)
  );

  stack_ptr #(
    .ADDR_W (ADDR_W),
    .BASE   (RET_BASE),
    .LIMIT  (RET_LIMIT)
  ) u_rs (
    .clk    (clk),
    .rst    (rst),
    .pop    (bus.RSPop),
    .we     (bus.RSPWrite),
    .sreset (bus.RSPRegReset),
    .sp     (rs_sp),
    .depth  (rs_dep),
    .empty  (rs_e),
    .full   (rs_f),
    .ovf    (rs_o),
    .unf    (rs_u)
  );

  // Second-of-stack wraps to BASE+1 when empty; the FSM never dereferences it then.
  assign bus.msp      = ms_sp;
  assign bus.msp_next = slot_above(ms_sp);
  assign bus.ms_depth = ms_dep;
  assign bus.ms_empty = ms_e;
  assign bus.ms_full  = ms_f;
  assign bus.ms_ovf   = ms_o;
  assign bus.ms_unf   = ms_u;

  assign bus.rsp      = rs_sp;
  assign bus.rs_depth = rs_dep;
  assign bus.rs_empty = rs_e;
  assign bus.rs_full  = rs_f;
  assign bus.rs_ovf   = rs_o;
  assign bus.rs_unf   = rs_u;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Randomized bench for stack_pointer_unit: a default-sized instance and a
// tiny-limit instance share stimulus; a depth-counting model predicts both.
module tb_stack_pointer_unit;
  import jala_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   cmp_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stack_pointer_unit_if bus_a ();
  stack_pointer_unit_if bus_b ();

  stack_pointer_unit dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  stack_pointer_unit #(
    .MAIN_BASE (16'hFFFE), .MAIN_LIMIT (16'hFFFC),
    .RET_BASE  (16'hEFFE), .RET_LIMIT  (16'hEFFB)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  // Model: each stack is a depth counter 0..cap; index 0/1 = A MS/RS, 2/3 = B MS/RS.
  logic [15:0] m_base [4] = '{16'hFFFE, 16'hEFFE, 16'hFFFE, 16'hEFFE};
  int          m_cap  [4] = '{4094, 4094, 2, 3};
  int          m_depth[4];
  bit          m_ovf  [4];
  bit          m_unf  [4];

  function automatic void model_step(int k, logic w, logic p, logic r);
    if (r) begin
      m_depth[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
    end else if (w && !p) begin
      if (m_depth[k] == m_cap[k]) m_ovf[k] = 1'b1;
      else m_depth[k] = m_depth[k] + 1;
    end else if (w && p) begin
      if (m_depth[k] == 0) m_unf[k] = 1'b1;
      else m_depth[k] = m_depth[k] - 1;
    end
  endfunction

  // Model state advances on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_depth[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
      end
    end else begin
      model_step(0, bus_a.MSPWrite, bus_a.MSPop, bus_a.MSPRegReset);
      model_step(1, bus_a.RSPWrite, bus_a.RSPop, bus_a.RSPRegReset);
      model_step(2, bus_a.MSPWrite, bus_a.MSPop, bus_a.MSPRegReset);
      model_step(3, bus_a.RSPWrite, bus_a.RSPop, bus_a.RSPRegReset);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] expect_vec(int k);
    logic [15:0] d;
    d = 16'(m_depth[k]);
    return {m_base[k] - d, d, (m_depth[k] == 0), (m_depth[k] == m_cap[k]), m_ovf[k], m_unf[k]};
  endfunction

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("a_ms", 64'({bus_a.msp, bus_a.ms_depth, bus_a.ms_empty, bus_a.ms_full, bus_a.ms_ovf, bus_a.ms_unf}), 64'(expect_vec(0)));
      chk("a_rs", 64'({bus_a.rsp, bus_a.rs_depth, bus_a.rs_empty, bus_a.rs_full, bus_a.rs_ovf, bus_a.rs_unf}), 64'(expect_vec(1)));
      chk("b_ms", 64'({bus_b.msp, bus_b.ms_depth, bus_b.ms_empty, bus_b.ms_full, bus_b.ms_ovf, bus_b.ms_unf}), 64'(expect_vec(2)));
      chk("b_rs", 64'({bus_b.rsp, bus_b.rs_depth, bus_b.rs_empty, bus_b.rs_full, bus_b.rs_ovf, bus_b.rs_unf}), 64'(expect_vec(3)));
      chk("a_msp_next", 64'(bus_a.msp_next), 64'(16'hFFFE - 16'(m_depth[0]) + 16'h0001));
      chk("b_msp_next", 64'(bus_b.msp_next), 64'(16'hFFFE - 16'(m_depth[2]) + 16'h0001));
    end
  end

  task automatic drive(input logic mw, mp, mr, rw, rp, rr);
    bus_a.MSPWrite = mw; bus_a.MSPop = mp; bus_a.MSPRegReset = mr;
    bus_a.RSPWrite = rw; bus_a.RSPop = rp; bus_a.RSPRegReset = rr;
    bus_b.MSPWrite = mw; bus_b.MSPop = mp; bus_b.MSPRegReset = mr;
    bus_b.RSPWrite = rw; bus_b.RSPop = rp; bus_b.RSPRegReset = rr;
  endtask

  // Apply one cycle of controls, then return to idle just after the edge.
  task automatic step(input logic mw, mp, mr, rw, rp, rr);
    drive(mw, mp, mr, rw, rp, rr);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values();
    chk("rst_msp", 64'(bus_a.msp), 64'(16'hFFFE));
    chk("rst_rsp", 64'(bus_a.rsp), 64'(16'hEFFE));
    chk("rst_msp_next", 64'(bus_a.msp_next), 64'(16'hFFFF));
    chk("rst_flags_a", 64'({bus_a.ms_ovf, bus_a.ms_unf, bus_a.rs_ovf, bus_a.rs_unf, bus_a.ms_full, bus_a.rs_full}), 64'(6'b000000));
    chk("rst_flags_b", 64'({bus_b.ms_ovf, bus_b.ms_unf, bus_b.rs_ovf, bus_b.rs_unf, bus_b.ms_full, bus_b.rs_full}), 64'(6'b000000));
    chk("rst_empty", 64'({bus_a.ms_empty, bus_a.rs_empty}), 64'(2'b11));
    chk("rst_depth", 64'({bus_a.ms_depth, bus_a.rs_depth}), 64'(32'h0));
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values();

    // Three pushes then one pop on the main stack
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("push3_msp", 64'(bus_a.msp), 64'(16'hFFFB));
    chk("push3_depth", 64'(bus_a.ms_depth), 64'(16'd3));
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pop_msp", 64'(bus_a.msp), 64'(16'hFFFC));
    chk("pop_msp_next", 64'(bus_a.msp_next), 64'(16'hFFFD));

    // Underflow is sticky until the matching RegReset
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("unf_msp", 64'(bus_a.msp), 64'(16'hFFFE));
    chk("unf_set", 64'(bus_a.ms_unf), 64'(1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("unf_sticky", 64'(bus_a.ms_unf), 64'(1'b1));
    chk("unf_rs_clean", 64'({bus_a.rs_unf, bus_a.rs_ovf}), 64'(2'b00));
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("unf_cleared", 64'(bus_a.ms_unf), 64'(1'b0));

    // Overflow on the small instance (limit FFFC)
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_full_no_ovf", 64'({bus_b.msp, bus_b.ms_full, bus_b.ms_ovf}), 64'({16'hFFFC, 1'b1, 1'b0}));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_third_push", 64'({bus_b.msp, bus_b.ms_full, bus_b.ms_ovf}), 64'({16'hFFFC, 1'b1, 1'b1}));
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Concurrent MS pop / RS push with depth 2 on both
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jp_pre", 64'({bus_a.msp, bus_a.rsp}), 64'({16'hFFFC, 16'hEFFC}));
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jp_post", 64'({bus_a.msp, bus_a.rsp}), 64'({16'hFFFD, 16'hEFFB}));

    // RegReset outranks a simultaneous push; RS untouched
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("prio_msp", 64'(bus_a.msp), 64'(16'hFFFE));
    chk("prio_rsp", 64'({bus_a.rsp, bus_a.rs_depth}), 64'({16'hEFFB, 16'd3}));

    // Random phase: pushes biased up so the large stacks gain real depth
    for (int i = 0; i < 4000; i++) begin
      logic mw, mp, mr, rw, rp, rr;
      mw = ($urandom_range(0, 3) != 0);
      mp = ($urandom_range(0, 9) < 4);
      mr = ($urandom_range(0, 99) == 0);
      rw = ($urandom_range(0, 3) != 0);
      rp = ($urandom_range(0, 9) < 4);
      rr = ($urandom_range(0, 99) == 0);
      step(mw, mp, mr, rw, rp, rr);
    end

    // Asynchronous reset asserted mid-cycle takes effect at once
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_msp", 64'(bus_a.msp), 64'(16'hFFFE));

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
